leaves_stream_mem: RTL

Leaf-storage memory for the kd-tree ANN engine, successor to the fixed full-row leaf memory. It accepts candidate patches as a valid/ready stream, one patch per cycle, and packs them into per-slot RAM banks. Leaf indices auto-increment, and a per-leaf valid bitmap tracks which leaves are complete. Reads are request-based with parametrised latency (1 or 2) and return a full leaf plus its valid flag to the search pipeline.

---
 rtl/leaves_mem_pkg.sv | 22 ++
 rtl/ram_sync_1r1w.sv | 29 ++
 rtl/leaves_stream_mem.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/leaves_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | leaves_mem_pkg : shared types and default geometry for the leaf memory    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package leaves_mem_pkg;

  localparam int LM_DATA_WIDTH = 11;
  localparam int LM_PATCH_SIZE = 5;
  localparam int LM_LEAF_SIZE  = 8;
  localparam int LM_NUM_LEAVES = 64;

  typedef logic [LM_PATCH_SIZE-1:0][LM_DATA_WIDTH-1:0] patch_t;
  typedef patch_t [LM_LEAF_SIZE-1:0] leaf_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } load_state_e;

endpackage
`default_nettype wire

// File: rtl/ram_sync_1r1w.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_sync_1r1w : simple dual-port RAM, registered read, read-before-write |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ram_sync_1r1w #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // A same-address read returns the pre-write word; there is no bypass.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/leaves_stream_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | leaves_stream_mem : streamed leaf loader into per-slot banks, pipelined   |
// | whole-leaf reads with completion flag.  Revision: 1.0                     |
// +--------------------------------------------------------------------------+
module leaves_stream_mem
  import leaves_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = LM_DATA_WIDTH,
  parameter int PATCH_SIZE   = LM_PATCH_SIZE,
  parameter int LEAF_SIZE    = LM_LEAF_SIZE,
  parameter int NUM_LEAVES   = LM_NUM_LEAVES,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = $clog2(NUM_LEAVES),
  parameter int SLOT_WIDTH   = $clog2(LEAF_SIZE)
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  clear,
  input  logic                                                  load_valid,
  output logic                                                  load_ready,
  input  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0]                 load_patch,
  output logic [ADDR_WIDTH-1:0]                                 load_leaf,
  output logic                                                  load_done,
  input  logic                                                  rd_req,
  input  logic [ADDR_WIDTH-1:0]                                 rd_adr,
  output logic                                                  rd_valid,
  output logic [LEAF_SIZE-1:0][PATCH_SIZE-1:0][DATA_WIDTH-1:0]  rd_data,
  output logic                                                  rd_leaf_valid,
  output logic [NUM_LEAVES-1:0]                                 leaf_valid_map
);

  localparam int PATCH_BITS = DATA_WIDTH * PATCH_SIZE;

  load_state_e             state, state_next;
  logic [SLOT_WIDTH-1:0]   slot_cnt;
  logic [ADDR_WIDTH-1:0]   leaf_cnt;
  logic [NUM_LEAVES-1:0]   valid_map;
  logic                    accept;
  logic                    slot_last;
  logic                    leaf_last;
  logic                    req_flag;
  logic                    valid_s1;
  logic                    flag_s1;
  logic [LEAF_SIZE-1:0][PATCH_BITS-1:0] ram_q;

  // Forcing ready low under clear/rst is what drops a coincident beat.
  assign load_ready = (state == FILL) && !clear && !rst;
  assign accept     = load_valid && load_ready;
  assign slot_last  = (slot_cnt == SLOT_WIDTH'(LEAF_SIZE - 1));
  assign leaf_last  = (leaf_cnt == ADDR_WIDTH'(NUM_LEAVES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = FILL;
    end else if (accept && slot_last && leaf_last) begin
      state_next = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      slot_cnt  <= '0;
      leaf_cnt  <= '0;
      valid_map <= '0;
    end else if (accept) begin
      if (slot_last) begin
        slot_cnt            <= '0;
        valid_map[leaf_cnt] <= 1'b1;
        if (!leaf_last) leaf_cnt <= leaf_cnt + ADDR_WIDTH'(1);
      end else begin
        slot_cnt <= slot_cnt + SLOT_WIDTH'(1);
      end
    end
  end

  assign load_done      = (state == FULL);
  assign load_leaf      = leaf_cnt;
  assign leaf_valid_map = valid_map;

  for (genvar i = 0; i < LEAF_SIZE; i++) begin : g_bank
    logic bank_wen;
    assign bank_wen = accept && (slot_cnt == SLOT_WIDTH'(i));

    ram_sync_1r1w #(
      .WIDTH (PATCH_BITS),
      .DEPTH (NUM_LEAVES),
      .AW    (ADDR_WIDTH)
    ) u_ram (
      .clk   (clk),
      .wen   (bank_wen),
      .waddr (leaf_cnt),
      .wdata (load_patch),
      .ren   (rd_req),
      .raddr (rd_adr),
      .rdata (ram_q[i])
    );
  end

  // Flag comes from the registered map, so it reflects state before this edge.
  assign req_flag = (int'(rd_adr) < NUM_LEAVES) ? valid_map[rd_adr] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_s1 <= 1'b0;
      flag_s1  <= 1'b0;
    end else begin
      valid_s1 <= rd_req;
      flag_s1  <= req_flag;
    end
  end

  if (READ_LATENCY == 2) begin : g_out_reg
    logic                                 valid_s2;
    logic                                 flag_s2;
    logic [LEAF_SIZE-1:0][PATCH_BITS-1:0] data_s2;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_s2 <= 1'b0;
        flag_s2  <= 1'b0;
        data_s2  <= '0;
      end else begin
        valid_s2 <= valid_s1;
        flag_s2  <= flag_s1;
        data_s2  <= ram_q;
      end
    end

    assign rd_valid      = valid_s2;
    assign rd_leaf_valid = flag_s2;
    assign rd_data       = data_s2;
  end else begin : g_out_raw
    assign rd_valid      = valid_s1;
    assign rd_leaf_valid = flag_s1;
    assign rd_data       = ram_q;
  end

endmodule
`default_nettype wire
